axi_spi_regfile: RTL and testbench

AXI_SPI_REGFILE -- requirements
Module: axi_spi_regfile

---
 rtl/axi_spi_regfile_if.sv | 62 ++++++
 rtl/axi_spi_regfile.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_axi_spi_regfile.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_spi_regfile_if.sv
// -----------------------------------------------------------------------------
// axi_spi_regfile_if
// Purpose : AXI4-Lite bus bundle (5-bit address, 32-bit data) used by the
//           SPI register file. It groups the five AXI4-Lite channels.
// Signals : write address  awaddr_i[4:0], awvalid_i, awready_o
//           write data     wdata_i[31:0], wstrb_i[3:0], wvalid_i, wready_o
//           write response bresp_o[1:0], bvalid_o, bready_i
//           read address   araddr_i[4:0], arvalid_i, arready_o
//           read data      rdata_o[31:0], rresp_o[1:0], rvalid_o, rready_i
//           The _i/_o suffixes are from the register file's point of view.
// Modports: slave  - the register file
//           master - the bus driver
// -----------------------------------------------------------------------------
interface axi_spi_regfile_if;
    logic [4:0]  awaddr_i;
    logic        awvalid_i;
    logic        awready_o;

    logic [31:0] wdata_i;
    logic [3:0]  wstrb_i;
    logic        wvalid_i;
    logic        wready_o;

    logic [1:0]  bresp_o;
    logic        bvalid_o;
    logic        bready_i;

    logic [4:0]  araddr_i;
    logic        arvalid_i;
    logic        arready_o;

    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rvalid_o;
    logic        rready_i;

    modport slave (
        input  awaddr_i, awvalid_i,
        output awready_o,
        input  wdata_i, wstrb_i, wvalid_i,
        output wready_o,
        output bresp_o, bvalid_o,
        input  bready_i,
        input  araddr_i, arvalid_i,
        output arready_o,
        output rdata_o, rresp_o, rvalid_o,
        input  rready_i
    );

    modport master (
        output awaddr_i, awvalid_i,
        input  awready_o,
        output wdata_i, wstrb_i, wvalid_i,
        input  wready_o,
        input  bresp_o, bvalid_o,
        output bready_i,
        output araddr_i, arvalid_i,
        input  arready_o,
        input  rdata_o, rresp_o, rvalid_o,
        output rready_i
    );
endinterface

// File: rtl/axi_spi_regfile.sv
// -----------------------------------------------------------------------------
// axi_spi_regfile
// Purpose : AXI4-Lite slave holding the configuration, transmit data and
//           status of an SPI register stage.
//           Word map: 0x00 CTRL, 0x04 TIMING, 0x08 TXDATA, 0x0C RXDATA (RO),
//           0x10 STATUS, 0x14..0x1C unmapped (SLVERR).
// Ports   : GCLK, RST (async active-low)    clock / reset
//           bus (axi_spi_regfile_if.slave)  AXI4-Lite channels
//           start_o                         one-cycle start pulse
//           spi_mode_o/sck_speed_o/word_len_o, IFG_o/CS_SCK_o/SCK_CS_o,
//           mosi_data_o                     held configuration / TX data
//           busy_i, miso_data_i             status / RX data from SPI stage
//           irq_o                           only with SPI_IRQ_EN
// Options : `define SPI_IRQ_EN adds irq_o = DONE & CTRL[7] (registered) and
//           makes CTRL[7] a read/write IRQ enable. Without it CTRL[7] reads 0.
// -----------------------------------------------------------------------------
module axi_spi_regfile (
    input  logic                    GCLK,
    input  logic                    RST,
    axi_spi_regfile_if.slave        bus,
    output logic                    start_o,
    output logic [1:0]              spi_mode_o,
    output logic [1:0]              sck_speed_o,
    output logic [1:0]              word_len_o,
    output logic [7:0]              IFG_o,
    output logic [7:0]              CS_SCK_o,
    output logic [7:0]              SCK_CS_o,
    output logic [31:0]             mosi_data_o,
    input  logic                    busy_i,
    input  logic [31:0]             miso_data_i
`ifdef SPI_IRQ_EN
    ,
    output logic                    irq_o
`endif
);

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_TIMING = 3'd1;
    localparam logic [2:0] ADDR_TXDATA = 3'd2;
    localparam logic [2:0] ADDR_RXDATA = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte-lane merge: lanes with strobe set take the new byte.
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] upd,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? upd[8*i +: 8] : cur[8*i +: 8];
        end
        return res;
    endfunction

    // ---------------------------------------------------------------- state
    w_state_t    w_state_r;
    r_state_t    r_state_r;
    logic        wr_en_r;       // 0 for the first cycle out of reset
    logic        bvalid_r;
    logic [1:0]  bresp_r;
    logic        arready_r;
    logic        rvalid_r;
    logic [31:0] rdata_r;
    logic [1:0]  rresp_r;

    logic [1:0]  mode_r;
    logic [1:0]  sck_r;
    logic [1:0]  wl_r;
    logic [7:0]  ifg_r;
    logic [7:0]  cs_sck_r;
    logic [7:0]  sck_cs_r;
    logic [31:0] txdata_r;
    logic        start_r;
    logic        done_r;
    logic        busy_d_r;

    // ---------------------------------------------------------------- comb
    logic        wr_hs_s;
    logic [2:0]  wr_idx_s;
    logic [1:0]  wr_resp_s;
    logic        wr_ok_s;
    logic        status_clr_s;
    logic        busy_fall_s;
    logic        rd_hs_s;
    logic [2:0]  rd_idx_s;
    logic [31:0] rd_data_s;
    logic [1:0]  rd_resp_s;
    logic        ctrl_irq_bit_s;
    logic        unused_s;

    // Address LSBs are irrelevant for a word-addressed map.
    assign unused_s = ^{bus.awaddr_i[1:0], bus.araddr_i[1:0]};

    // Both write channels are accepted together, only when both are offered.
    assign wr_hs_s  = wr_en_r && (w_state_r == W_IDLE) && bus.awvalid_i && bus.wvalid_i;
    assign wr_idx_s = bus.awaddr_i[4:2];
    assign wr_ok_s  = (wr_resp_s == RESP_OKAY);
    assign rd_hs_s  = arready_r && bus.arvalid_i;
    assign rd_idx_s = bus.araddr_i[4:2];

    assign busy_fall_s  = busy_d_r && !busy_i;
    assign status_clr_s = wr_hs_s && (wr_idx_s == ADDR_STATUS) && bus.wdata_i[1];

    assign bus.awready_o = wr_hs_s;
    assign bus.wready_o  = wr_hs_s;
    assign bus.bvalid_o  = bvalid_r;
    assign bus.bresp_o   = bresp_r;
    assign bus.arready_o = arready_r;
    assign bus.rvalid_o  = rvalid_r;
    assign bus.rdata_o   = rdata_r;
    assign bus.rresp_o   = rresp_r;

    assign start_o     = start_r;
    assign spi_mode_o  = mode_r;
    assign sck_speed_o = sck_r;
    assign word_len_o  = wl_r;
    assign IFG_o       = ifg_r;
    assign CS_SCK_o    = cs_sck_r;
    assign SCK_CS_o    = sck_cs_r;
    assign mosi_data_o = txdata_r;

`ifdef SPI_IRQ_EN
    logic irq_en_r;
    logic irq_r;

    assign ctrl_irq_bit_s = irq_en_r;
    assign irq_o          = irq_r;

    // Interrupt enable bit and registered interrupt output.
    always_ff @(posedge GCLK or negedge RST) begin
        if (!RST) begin
            irq_en_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            if (wr_hs_s && wr_ok_s && (wr_idx_s == ADDR_CTRL) && bus.wstrb_i[0]) begin
                irq_en_r <= bus.wdata_i[7];
            end
            irq_r <= done_r && irq_en_r;
        end
    end
`else
    assign ctrl_irq_bit_s = 1'b0;
`endif

    // Write response code: config registers refuse updates while the SPI
    // stage is busy; RXDATA and holes are never writable.
    always_comb begin
        wr_resp_s = RESP_OKAY;
        case (wr_idx_s)
            ADDR_CTRL, ADDR_TIMING, ADDR_TXDATA: begin
                if (busy_i) begin
                    wr_resp_s = RESP_SLVERR;
                end else begin
                    wr_resp_s = RESP_OKAY;
                end
            end
            ADDR_STATUS: wr_resp_s = RESP_OKAY;
            default:     wr_resp_s = RESP_SLVERR;
        endcase
    end

    // Read data mux, captured into rdata_r at the address handshake.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        rd_resp_s = RESP_OKAY;
        case (rd_idx_s)
            ADDR_CTRL:   rd_data_s = {24'h00_0000, ctrl_irq_bit_s, wl_r, sck_r, mode_r, 1'b0};
            ADDR_TIMING: rd_data_s = {8'h00, sck_cs_r, cs_sck_r, ifg_r};
            ADDR_TXDATA: rd_data_s = txdata_r;
            ADDR_RXDATA: rd_data_s = miso_data_i;
            ADDR_STATUS: rd_data_s = {30'h0000_0000, done_r, busy_i};
            default: begin
                rd_data_s = 32'h0000_0000;
                rd_resp_s = RESP_SLVERR;
            end
        endcase
    end

    // Write channel FSM: accept, then hold the response until bready_i.
    always_ff @(posedge GCLK or negedge RST) begin
        if (!RST) begin
            w_state_r <= W_IDLE;
            wr_en_r   <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else begin
            wr_en_r <= 1'b1;
            case (w_state_r)
                W_IDLE: begin
                    if (wr_hs_s) begin
                        w_state_r <= W_RESP;
                        bvalid_r  <= 1'b1;
                        bresp_r   <= wr_resp_s;
                    end
                end
                W_RESP: begin
                    if (bus.bready_i) begin
                        w_state_r <= W_IDLE;
                        bvalid_r  <= 1'b0;
                        bresp_r   <= RESP_OKAY;
                    end
                end
                default: begin
                    w_state_r <= W_IDLE;
                    bvalid_r  <= 1'b0;
                    bresp_r   <= RESP_OKAY;
                end
            endcase
        end
    end

    // Configuration / TX data registers and the start pulse.
    always_ff @(posedge GCLK or negedge RST) begin
        if (!RST) begin
            mode_r   <= 2'b00;
            sck_r    <= 2'b00;
            wl_r     <= 2'b00;
            ifg_r    <= 8'h00;
            cs_sck_r <= 8'h00;
            sck_cs_r <= 8'h00;
            txdata_r <= 32'h0000_0000;
            start_r  <= 1'b0;
        end else begin
            start_r <= 1'b0;
            // wr_ok_s already excludes busy for the config registers
            if (wr_hs_s && wr_ok_s) begin
                case (wr_idx_s)
                    ADDR_CTRL: begin
                        if (bus.wstrb_i[0]) begin
                            mode_r  <= bus.wdata_i[2:1];
                            sck_r   <= bus.wdata_i[4:3];
                            wl_r    <= bus.wdata_i[6:5];
                            start_r <= bus.wdata_i[0];
                        end
                    end
                    ADDR_TIMING: begin
                        if (bus.wstrb_i[0]) ifg_r    <= bus.wdata_i[7:0];
                        if (bus.wstrb_i[1]) cs_sck_r <= bus.wdata_i[15:8];
                        if (bus.wstrb_i[2]) sck_cs_r <= bus.wdata_i[23:16];
                    end
                    ADDR_TXDATA: txdata_r <= merge_bytes(txdata_r, bus.wdata_i, bus.wstrb_i);
                    default: ;
                endcase
            end
        end
    end

    // DONE: set on busy falling edge, cleared by STATUS write; set wins.
    always_ff @(posedge GCLK or negedge RST) begin
        if (!RST) begin
            busy_d_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            busy_d_r <= busy_i;
            if (busy_fall_s) begin
                done_r <= 1'b1;
            end else if (status_clr_s) begin
                done_r <= 1'b0;
            end
        end
    end

    // Read channel FSM: capture data at address handshake, hold until rready_i.
    always_ff @(posedge GCLK or negedge RST) begin
        if (!RST) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0000_0000;
            rresp_r   <= RESP_OKAY;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (rd_hs_s) begin
                        r_state_r <= R_DATA;
                        arready_r <= 1'b0;
                        rvalid_r  <= 1'b1;
                        rdata_r   <= rd_data_s;
                        rresp_r   <= rd_resp_s;
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (bus.rready_i) begin
                        r_state_r <= R_IDLE;
                        arready_r <= 1'b1;
                        rvalid_r  <= 1'b0;
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                    arready_r <= 1'b0;
                    rvalid_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_spi_regfile.sv
// -----------------------------------------------------------------------------
// tb_axi_spi_regfile
// Purpose : self-checking bench for axi_spi_regfile. Directed steps followed by
//           a randomized mix of reads, writes and busy toggles, all compared
//           against a register-level reference model kept in this file.
//           Works with or without `define SPI_IRQ_EN.
// -----------------------------------------------------------------------------
module tb_axi_spi_regfile;

    logic        GCLK = 1'b0;
    logic        RST  = 1'b0;
    logic        start_o;
    logic [1:0]  spi_mode_o, sck_speed_o, word_len_o;
    logic [7:0]  IFG_o, CS_SCK_o, SCK_CS_o;
    logic [31:0] mosi_data_o;
    logic        busy_i = 1'b0;
    logic [31:0] miso_data_i = 32'h0;
`ifdef SPI_IRQ_EN
    logic        irq_o;
`endif

    int checks    = 0;
    int failures  = 0;
    int start_cnt = 0;

    axi_spi_regfile_if bus();

    axi_spi_regfile dut (
        .GCLK        (GCLK),
        .RST         (RST),
        .bus         (bus),
        .start_o     (start_o),
        .spi_mode_o  (spi_mode_o),
        .sck_speed_o (sck_speed_o),
        .word_len_o  (word_len_o),
        .IFG_o       (IFG_o),
        .CS_SCK_o    (CS_SCK_o),
        .SCK_CS_o    (SCK_CS_o),
        .mosi_data_o (mosi_data_o),
        .busy_i      (busy_i),
        .miso_data_i (miso_data_i)
`ifdef SPI_IRQ_EN
        ,
        .irq_o       (irq_o)
`endif
    );

    always #5 GCLK = ~GCLK;

    // Count start pulses, sampled shortly after each rising edge.
    always @(posedge GCLK) begin
        #2;
        if (start_o === 1'b1) start_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ reference model
    logic [1:0] m_mode, m_sck, m_wl;
    logic       m_irq_en, m_done, m_busy;
    logic [7:0] m_tim [3];
    logic [7:0] m_tx  [4];

    function automatic void model_reset();
        m_mode = 2'd0; m_sck = 2'd0; m_wl = 2'd0;
        m_irq_en = 1'b0; m_done = 1'b0;
        for (int b = 0; b < 3; b++) m_tim[b] = 8'h00;
        for (int b = 0; b < 4; b++) m_tx[b]  = 8'h00;
    endfunction

    // Applies a write to the model; returns expected bresp and start pulse.
    function automatic logic [1:0] model_write(input logic [4:0] a, input logic [31:0] d,
                                               input logic [3:0] s, output logic exp_start);
        int idx;
        idx = a / 4;
        exp_start = 1'b0;
        if (idx == 3 || idx > 4) return 2'b10;
        if (idx == 4) begin
            if (d[1]) m_done = 1'b0;
            return 2'b00;
        end
        if (m_busy) return 2'b10;
        if (idx == 0) begin
            if (s[0]) begin
                m_mode = 2'((d >> 1) % 4);
                m_sck  = 2'((d >> 3) % 4);
                m_wl   = 2'((d >> 5) % 4);
                exp_start = d[0];
`ifdef SPI_IRQ_EN
                m_irq_en = d[7];
`endif
            end
        end else if (idx == 1) begin
            for (int b = 0; b < 3; b++) if (s[b]) m_tim[b] = d[8*b +: 8];
        end else begin
            for (int b = 0; b < 4; b++) if (s[b]) m_tx[b] = d[8*b +: 8];
        end
        return 2'b00;
    endfunction

    // Expected {rresp, rdata} for a read.
    function automatic logic [33:0] model_read(input logic [4:0] a, input logic [31:0] miso);
        int idx;
        logic [31:0] v;
        idx = a / 4;
        case (idx)
            0: v = (32'(m_irq_en) << 7) + (32'(m_wl) << 5) + (32'(m_sck) << 3) + (32'(m_mode) << 1);
            1: v = {8'h00, m_tim[2], m_tim[1], m_tim[0]};
            2: v = {m_tx[3], m_tx[2], m_tx[1], m_tx[0]};
            3: v = miso;
            4: v = (32'(m_done) << 1) + 32'(m_busy);
            default: return {2'b10, 32'h0};
        endcase
        return {2'b00, v};
    endfunction

    // ------------------------------------------------------------ helpers
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cfg(input string tag);
        chk({tag, "_ctrl"}, {26'h0, spi_mode_o, sck_speed_o, word_len_o}, {26'h0, m_mode, m_sck, m_wl});
        chk({tag, "_timing"}, {8'h0, SCK_CS_o, CS_SCK_o, IFG_o}, {8'h0, m_tim[2], m_tim[1], m_tim[0]});
        chk({tag, "_txdata"}, mosi_data_o, {m_tx[3], m_tx[2], m_tx[1], m_tx[0]});
    endtask

    task automatic set_busy(input logic v);
        if (m_busy && !v) m_done = 1'b1;
        m_busy = v;
        busy_i = v;
        repeat (2) @(negedge GCLK);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input string tag);
        logic [1:0] er;
        logic       es;
        int         n, sc0;
        er = model_write(a, d, s, es);
        sc0 = start_cnt;
        bus.awaddr_i = a; bus.wdata_i = d; bus.wstrb_i = s;
        bus.awvalid_i = 1'b1; bus.wvalid_i = 1'b1;
        #1;
        n = 0;
        while (!(bus.awready_o === 1'b1 && bus.wready_o === 1'b1) && n < 16) begin
            @(negedge GCLK);
            n++;
        end
        chk({tag, "_wready_wait"}, 32'(n < 16), 32'd1);
        @(negedge GCLK);
        bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
        chk({tag, "_bvalid"}, {31'h0, bus.bvalid_o}, 32'd1);
        chk({tag, "_bresp"}, {30'h0, bus.bresp_o}, {30'h0, er});
        chk({tag, "_start"}, {31'h0, start_o}, {31'h0, es});
        bus.bready_i = 1'b1;
        @(negedge GCLK);
        bus.bready_i = 1'b0;
        chk({tag, "_bvalid_clr"}, {31'h0, bus.bvalid_o}, 32'd0);
        chk({tag, "_start_cnt"}, 32'(start_cnt - sc0), {31'h0, es});
    endtask

    task automatic do_read(input logic [4:0] a, input int hold, input string tag);
        logic [33:0] e;
        int n;
        e = model_read(a, miso_data_i);
        n = 0;
        while (bus.arready_o !== 1'b1 && n < 16) begin
            @(negedge GCLK);
            n++;
        end
        chk({tag, "_arready_wait"}, 32'(n < 16), 32'd1);
        bus.araddr_i = a; bus.arvalid_i = 1'b1;
        @(negedge GCLK);
        bus.arvalid_i = 1'b0;
        chk({tag, "_rvalid"}, {31'h0, bus.rvalid_o}, 32'd1);
        chk({tag, "_rdata"}, bus.rdata_o, e[31:0]);
        chk({tag, "_rresp"}, {30'h0, bus.rresp_o}, {30'h0, e[33:32]});
        for (int h = 0; h < hold; h++) begin
            @(negedge GCLK);
            chk({tag, "_hold_rvalid"}, {31'h0, bus.rvalid_o}, 32'd1);
            chk({tag, "_hold_rdata"}, bus.rdata_o, e[31:0]);
        end
        bus.rready_i = 1'b1;
        @(negedge GCLK);
        bus.rready_i = 1'b0;
        chk({tag, "_rvalid_clr"}, {31'h0, bus.rvalid_o}, 32'd0);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [33:0] e;
        logic [1:0]  er;
        logic        es;
        int          sc0, op;
        logic [4:0]  a;

        bus.awaddr_i = 5'h0; bus.wdata_i = 32'h0; bus.wstrb_i = 4'h0;
        bus.bready_i = 1'b0; bus.araddr_i = 5'h0; bus.rready_i = 1'b0;
        m_busy = 1'b0;
        model_reset();

        // Reset: readies stay low even with valids offered.
        bus.awvalid_i = 1'b1; bus.wvalid_i = 1'b1; bus.arvalid_i = 1'b1;
        repeat (2) @(negedge GCLK);
        chk("rst_awready", {31'h0, bus.awready_o}, 32'd0);
        chk("rst_wready", {31'h0, bus.wready_o}, 32'd0);
        chk("rst_arready", {31'h0, bus.arready_o}, 32'd0);
        chk("rst_bvalid", {31'h0, bus.bvalid_o}, 32'd0);
        chk("rst_rvalid", {31'h0, bus.rvalid_o}, 32'd0);
        chk("rst_start", {31'h0, start_o}, 32'd0);
        chk_cfg("rst");
        bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0; bus.arvalid_i = 1'b0;
        RST = 1'b1;
        repeat (2) @(negedge GCLK);

        // CTRL write with START.
        do_write(5'h00, 32'h0000_0035, 4'hF, "ctrl35");
        chk("ctrl35_mode", {30'h0, spi_mode_o}, 32'd2);
        chk("ctrl35_sck", {30'h0, sck_speed_o}, 32'd2);
        chk("ctrl35_wl", {30'h0, word_len_o}, 32'd1);
        do_read(5'h00, 0, "ctrl35_rd");

        // TIMING partial strobe.
        do_write(5'h04, 32'h00AA_BBCC, 4'h5, "tim");
        chk("tim_ifg", {24'h0, IFG_o}, 32'h0000_00CC);
        chk("tim_cs_sck", {24'h0, CS_SCK_o}, 32'h0000_0000);
        chk("tim_sck_cs", {24'h0, SCK_CS_o}, 32'h0000_00AA);

        // Write while busy is refused.
        set_busy(1'b1);
        do_write(5'h00, 32'h0000_0001, 4'hF, "busy_ctrl");
        chk_cfg("busy_ctrl");
        do_read(5'h10, 0, "busy_status");

        // DONE set on busy falling edge, cleared by STATUS write.
        set_busy(1'b0);
        do_read(5'h10, 0, "done_set");
        do_write(5'h10, 32'h0000_0002, 4'hF, "done_clr_wr");
        do_read(5'h10, 0, "done_clr");

        // Unmapped read held with rready low.
        do_read(5'h14, 3, "unmapped");
        miso_data_i = 32'hDEAD_BEEF;
        do_read(5'h0C, 1, "rxdata");
        do_write(5'h0C, 32'h1234_5678, 4'hF, "rx_wr");
        do_write(5'h18, 32'h1234_5678, 4'hF, "hole_wr");

        // Same-cycle STATUS read and STATUS clear: read sees pre-write DONE.
        set_busy(1'b1);
        set_busy(1'b0);
        e  = model_read(5'h10, miso_data_i);
        er = model_write(5'h10, 32'h0000_0002, 4'hF, es);
        bus.awaddr_i = 5'h10; bus.wdata_i = 32'h0000_0002; bus.wstrb_i = 4'hF;
        bus.araddr_i = 5'h10;
        bus.awvalid_i = 1'b1; bus.wvalid_i = 1'b1; bus.arvalid_i = 1'b1;
        #1;
        chk("same_awready", {31'h0, bus.awready_o}, 32'd1);
        chk("same_arready", {31'h0, bus.arready_o}, 32'd1);
        @(negedge GCLK);
        bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0; bus.arvalid_i = 1'b0;
        chk("same_rdata", bus.rdata_o, e[31:0]);
        chk("same_bresp", {30'h0, bus.bresp_o}, {30'h0, er});
        chk("same_bvalid", {31'h0, bus.bvalid_o}, 32'd1);
        bus.bready_i = 1'b1; bus.rready_i = 1'b1;
        @(negedge GCLK);
        bus.bready_i = 1'b0; bus.rready_i = 1'b0;
        do_read(5'h10, 0, "same_after");

`ifdef SPI_IRQ_EN
        do_write(5'h00, 32'h0000_0080, 4'h1, "irq_en");
        set_busy(1'b1);
        chk("irq_idle", {31'h0, irq_o}, 32'd0);
        set_busy(1'b0);
        chk("irq_set", {31'h0, irq_o}, 32'd1);
        repeat (3) @(negedge GCLK);
        chk("irq_held", {31'h0, irq_o}, 32'd1);
        do_write(5'h10, 32'h0000_0002, 4'hF, "irq_clr_wr");
        chk("irq_clr", {31'h0, irq_o}, 32'd0);
`endif

        // Randomized traffic against the model.
        for (int it = 0; it < 80; it++) begin
            op = int'($urandom_range(0, 9));
            a  = 5'($urandom_range(0, 31));
            if (op == 0) begin
                set_busy(!m_busy);
            end else if (op < 5) begin
                do_write(a, $urandom, 4'($urandom), "rnd_wr");
                chk_cfg("rnd_wr");
            end else begin
                miso_data_i = $urandom;
                do_read(a, int'($urandom_range(0, 2)), "rnd_rd");
            end
        end
        if (m_busy) set_busy(1'b0);

        // Reset in the middle of a write response and a read response.
        bus.awaddr_i = 5'h00; bus.wdata_i = 32'h0000_0001; bus.wstrb_i = 4'hF;
        bus.araddr_i = 5'h04;
        bus.awvalid_i = 1'b1; bus.wvalid_i = 1'b1; bus.arvalid_i = 1'b1;
        @(negedge GCLK);
        bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0; bus.arvalid_i = 1'b0;
        chk("abort_bvalid_pre", {31'h0, bus.bvalid_o}, 32'd1);
        RST = 1'b0;
        #1;
        chk("abort_bvalid", {31'h0, bus.bvalid_o}, 32'd0);
        chk("abort_rvalid", {31'h0, bus.rvalid_o}, 32'd0);
        chk("abort_start", {31'h0, start_o}, 32'd0);
        model_reset();
        @(negedge GCLK);
        sc0 = start_cnt;
        RST = 1'b1;
        repeat (3) @(negedge GCLK);
        chk("abort_no_start", 32'(start_cnt - sc0), 32'd0);
        chk("abort_bvalid_post", {31'h0, bus.bvalid_o}, 32'd0);
        chk("abort_rvalid_post", {31'h0, bus.rvalid_o}, 32'd0);
        chk_cfg("abort");
        do_read(5'h10, 0, "abort_status");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
